// File: rtl/tm_lif_array_if.sv
// Bus bundle for the time-multiplexed LIF array: update controls in,
// spike event stream and membrane trace out.
interface tm_lif_array_if #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 8
);
  localparam int IDX_W = $clog2(N_NEURONS);

  logic                 en;
  logic [WIDTH-1:0]     current;
  logic                 thr_we;
  logic [WIDTH-1:0]     thr_data;
  logic [IDX_W-1:0]     tm_idx;
  logic [N_NEURONS-1:0] spike;
  logic                 spike_valid;
  logic [IDX_W-1:0]     spike_id;
  logic [WIDTH-1:0]     state_out;
  logic [IDX_W-1:0]     state_id;
  logic                 frame_done;

  modport slave (
    input  en, current, thr_we, thr_data,
    output tm_idx, spike, spike_valid, spike_id, state_out, state_id, frame_done
  );

  modport master (
    output en, current, thr_we, thr_data,
    input  tm_idx, spike, spike_valid, spike_id, state_out, state_id, frame_done
  );
endinterface

// File: rtl/tm_lif_array.sv
// Time-multiplexed leaky integrate-and-fire array: one shared update datapath
// walks N_NEURONS membrane states round-robin, one neuron per enabled cycle.
module tm_lif_array #(
  parameter int WIDTH       = 8,
  parameter int N_NEURONS   = 8,
  parameter int LEAK_SHIFT  = 3,
  parameter int IN_SHIFT    = 1,
  parameter int THRESH_INIT = 127,
  parameter int REFRACTORY  = 2
) (
  input  logic           clk,
  input  logic           rst,
  tm_lif_array_if.slave  bus
);
  localparam int IDX_W = $clog2(N_NEURONS);
  // +2 keeps the counter at least one bit wide even when REFRACTORY is 0
  localparam int RW    = $clog2(REFRACTORY + 2);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_NEURONS - 1);

  logic [WIDTH-1:0]     v_q [N_NEURONS];
  logic [WIDTH-1:0]     v_d [N_NEURONS];
  logic [RW-1:0]        r_q [N_NEURONS];
  logic [RW-1:0]        r_d [N_NEURONS];
  logic [IDX_W-1:0]     slot_q, slot_d;
  logic [IDX_W-1:0]     spike_id_q, spike_id_d;
  logic [IDX_W-1:0]     state_id_q, state_id_d;
  logic [N_NEURONS-1:0] spike_q, spike_d;
  logic                 spike_valid_q, spike_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [WIDTH-1:0]     thr_q, thr_d;
  logic [WIDTH-1:0]     state_out_q, state_out_d;

  logic [WIDTH-1:0]     leaked;
  logic [WIDTH-1:0]     in_c;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH-1:0]     sum_sat;

  always_comb begin
    leaked  = v_q[slot_q] - (v_q[slot_q] >> LEAK_SHIFT);
    in_c    = bus.current >> IN_SHIFT;
    sum_w   = {1'b0, leaked} + {1'b0, in_c};
    sum_sat = sum_w[WIDTH] ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
  end

  always_comb begin
    v_d           = v_q;
    r_d           = r_q;
    slot_d        = slot_q;
    spike_d       = spike_q;
    spike_id_d    = spike_id_q;
    state_id_d    = state_id_q;
    state_out_d   = state_out_q;
    spike_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    // the update below still compares against thr_q, so a same-cycle write
    // only takes effect from the next update
    thr_d         = bus.thr_we ? bus.thr_data : thr_q;

    if (bus.en) begin
      if (r_q[slot_q] != '0) begin
        v_d[slot_q]     = '0;
        r_d[slot_q]     = r_q[slot_q] - RW'(1);
        spike_d[slot_q] = 1'b0;
        state_out_d     = '0;
      end else if (sum_sat >= thr_q) begin
        v_d[slot_q]     = '0;
        r_d[slot_q]     = RW'(REFRACTORY);
        spike_d[slot_q] = 1'b1;
        spike_valid_d   = 1'b1;
        spike_id_d      = slot_q;
        state_out_d     = '0;
      end else begin
        v_d[slot_q]     = sum_sat;
        spike_d[slot_q] = 1'b0;
        state_out_d     = sum_sat;
      end
      state_id_d   = slot_q;
      frame_done_d = (slot_q == LAST_SLOT);
      slot_d       = (slot_q == LAST_SLOT) ? '0 : slot_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= '0;
        r_q[i] <= '0;
      end
      slot_q        <= '0;
      spike_q       <= '0;
      spike_id_q    <= '0;
      state_id_q    <= '0;
      state_out_q   <= '0;
      spike_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      thr_q         <= WIDTH'(THRESH_INIT);
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= v_d[i];
        r_q[i] <= r_d[i];
      end
      slot_q        <= slot_d;
      spike_q       <= spike_d;
      spike_id_q    <= spike_id_d;
      state_id_q    <= state_id_d;
      state_out_q   <= state_out_d;
      spike_valid_q <= spike_valid_d;
      frame_done_q  <= frame_done_d;
      thr_q         <= thr_d;
    end
  end

  assign bus.tm_idx      = slot_q;
  assign bus.spike       = spike_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.spike_id    = spike_id_q;
  assign bus.state_out   = state_out_q;
  assign bus.state_id    = state_id_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_tm_lif_array.sv
// Directed bench for tm_lif_array (N=4): hand-computed membrane traces for
// integrate/spike/refractory, saturation, leak, enable hold, reset and threshold writes.
module tb_tm_lif_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  tm_lif_array_if #(.WIDTH(8), .N_NEURONS(4)) bus ();

  tm_lif_array #(
    .WIDTH(8), .N_NEURONS(4), .LEAK_SHIFT(3), .IN_SHIFT(1),
    .THRESH_INIT(127), .REFRACTORY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // inputs change at the falling edge; outputs are read at the next falling edge
  task automatic step(input logic e, input int cur, input logic we, input int td);
    bus.en       = e;
    bus.current  = 8'(cur);
    bus.thr_we   = we;
    bus.thr_data = 8'(td);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 200, 1'b1, 9);
    rst = 1'b0;
    check_eq("rst_tm_idx", int'(bus.tm_idx), 0);
    check_eq("rst_spike", int'(bus.spike), 0);
    check_eq("rst_spike_valid", int'(bus.spike_valid), 0);
    check_eq("rst_spike_id", int'(bus.spike_id), 0);
    check_eq("rst_state_out", int'(bus.state_out), 0);
    check_eq("rst_state_id", int'(bus.state_id), 0);
    check_eq("rst_frame_done", int'(bus.frame_done), 0);
  endtask

  task automatic upd(input string tag, input int slot, input int cur,
                     input int ev, input bit esp);
    check_eq({tag, "_tm_idx"}, int'(bus.tm_idx), slot);
    step(1'b1, cur, 1'b0, 0);
    check_eq({tag, "_state_out"}, int'(bus.state_out), ev);
    check_eq({tag, "_state_id"}, int'(bus.state_id), slot);
    check_eq({tag, "_spike_valid"}, int'(bus.spike_valid), int'(esp));
    check_eq({tag, "_spike_bit"}, int'(bus.spike[slot]), int'(esp));
    check_eq({tag, "_frame_done"}, int'(bus.frame_done), (slot == 3) ? 1 : 0);
    if (esp) check_eq({tag, "_spike_id"}, int'(bus.spike_id), slot);
  endtask

  initial begin
    int ev1 [6] = '{100, 0, 0, 0, 100, 0};
    bit sp1 [6] = '{0, 1, 0, 0, 0, 1};
    int ev2 [3] = '{127, 239, 0};
    bit sp2 [3] = '{0, 0, 1};
    int ev3 [4] = '{88, 77, 68, 60};

    bus.en = 1'b0; bus.current = '0; bus.thr_we = 1'b0; bus.thr_data = '0;
    @(negedge clk);

    // integrate, spike, refractory, integrate again
    do_reset();
    for (int f = 0; f < 6; f++)
      for (int s = 0; s < 4; s++) upd("t1", s, 200, ev1[f], sp1[f]);

    // saturation at threshold 255
    do_reset();
    step(1'b0, 0, 1'b1, 255);
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 4; s++) upd("t2", s, 255, ev2[f], sp2[f]);

    // pure leak decay
    do_reset();
    for (int s = 0; s < 4; s++) upd("t3_load", s, 200, 100, 1'b0);
    for (int f = 0; f < 4; f++)
      for (int s = 0; s < 4; s++) upd("t3", s, 0, ev3[f], 1'b0);

    // enable low holds slot 2 and all state
    do_reset();
    for (int s = 0; s < 4; s++) upd("t4_load", s, 200, 100, 1'b0);
    upd("t4_pre", 0, 200, 0, 1'b1);
    upd("t4_pre", 1, 200, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 200, 1'b0, 0);
      check_eq("t4_hold_tm_idx", int'(bus.tm_idx), 2);
      check_eq("t4_hold_spike", int'(bus.spike), 3);
      check_eq("t4_hold_spike_valid", int'(bus.spike_valid), 0);
      check_eq("t4_hold_frame_done", int'(bus.frame_done), 0);
      check_eq("t4_hold_state_out", int'(bus.state_out), 0);
      check_eq("t4_hold_state_id", int'(bus.state_id), 1);
    end
    upd("t4_resume", 2, 200, 0, 1'b1);
    upd("t4_resume", 3, 200, 0, 1'b1);
    check_eq("t4_spike_all", int'(bus.spike), 15);

    // reset mid-frame clears refractory state and the threshold
    do_reset();
    for (int s = 0; s < 4; s++) upd("t5_load", s, 200, 100, 1'b0);
    for (int s = 0; s < 4; s++) upd("t5_fire", s, 200, 0, 1'b1);
    for (int s = 0; s < 3; s++) upd("t5_refr", s, 200, 0, 1'b0);
    step(1'b0, 0, 1'b1, 255);
    do_reset();
    for (int s = 0; s < 4; s++) upd("t5_post", s, 200, 100, 1'b0);
    upd("t5_thr127", 0, 200, 0, 1'b1);

    // same-cycle threshold write uses the old threshold
    do_reset();
    for (int s = 0; s < 4; s++) upd("t6_load", s, 200, 100, 1'b0);
    for (int s = 0; s < 4; s++) upd("t6_leak", s, 0, 88, 1'b0);
    check_eq("t6_tm_idx", int'(bus.tm_idx), 0);
    step(1'b1, 60, 1'b1, 50);
    check_eq("t6_old_thr_state", int'(bus.state_out), 107);
    check_eq("t6_old_thr_valid", int'(bus.spike_valid), 0);
    for (int s = 1; s < 4; s++) upd("t6_new_thr", s, 0, 0, 1'b1);
    upd("t6_fire94", 0, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tm_lif_array.md
Name: tm_lif_array

Overview:
Parametrised time-multiplexed leaky integrate-and-fire neuron array. One shared update datapath serves N_NEURONS membrane states in round-robin, one neuron per enabled cycle. Adds leak, saturation, refractory period, a runtime-programmable threshold and a spike event stream. It sits between the input current source and the downstream spike consumer or router.

Parameters:
WIDTH, 8, membrane/current/threshold width in bits
N_NEURONS, 8, neuron count (>=2); index width IDX_W = clog2(N_NEURONS)
LEAK_SHIFT, 3, leak per update = v >> LEAK_SHIFT
IN_SHIFT, 1, input scaling: contribution = current >> IN_SHIFT
THRESH_INIT, 127, threshold value after reset
REFRACTORY, 2, number of own-slot updates a neuron is held after a spike (0 = none)

Ports:
clk  in  1  system clock
rst  in  1  reset
en  in  1  advance/update enable
current  in  WIDTH  input current for the neuron in slot tm_idx this cycle
thr_we  in  1  threshold write strobe
thr_data  in  WIDTH  new threshold value
tm_idx  out  IDX_W  neuron served this cycle (combinational from slot counter)
spike  out  N_NEURONS  per-neuron spike flag, registered
spike_valid  out  1  one-cycle spike event pulse
spike_id  out  IDX_W  neuron index of the event
state_out  out  WIDTH  membrane value just written
state_id  out  IDX_W  neuron index of state_out
frame_done  out  1  pulse after slot N_NEURONS-1 is updated

Interface: one clock; reset is synchronous and active-high. All state changes occur on the rising edge of clk.

Behaviour:
- Reset (rst=1 at an edge): all membranes v[i]=0, refractory counters r[i]=0, slot counter=0, threshold=THRESH_INIT, spike=0, spike_valid=0, spike_id=0, state_out=0, state_id=0, frame_done=0. Reset overrides en and thr_we. Reset mid-frame discards any partial frame; the next slot after reset is 0.
- en=0: slot counter, v[], r[] and spike[] hold. spike_valid and frame_done are 0. state_out and state_id hold. thr_we is still honoured.
- en=1: update neuron k=tm_idx. Results are registered at this edge, so latency is 1 cycle.
  - If r[k]>0: v[k]<=0, r[k]<=r[k]-1, spike[k]<=0. current is ignored.
  - Else: leaked = v[k] - (v[k]>>LEAK_SHIFT). sum = leaked + (current>>IN_SHIFT), computed in WIDTH+1 bits and saturated to 2^WIDTH-1.
    - If sum >= threshold: spike[k]<=1, v[k]<=0, r[k]<=REFRACTORY, spike_valid<=1, spike_id<=k.
    - Otherwise: spike[k]<=0, v[k]<=sum.
  - state_out<=new v[k]. state_id<=k.
  - Slot counter wraps from N_NEURONS-1 to 0. frame_done<=1 when k==N_NEURONS-1.
- spike[i] is rewritten only in neuron i's own slot. Other bits hold.
- spike_valid is 0 in every cycle with no spike.
- Threshold write: thr_we=1 loads thr_data at the edge. An update in the same cycle compares against the old threshold; the new value applies from the next cycle.
- The threshold is global to all neurons. A threshold of 0 makes every non-refractory update spike.
- Non-power-of-2 N_NEURONS must wrap correctly, with no idle slots.

Test Plan (WIDTH=8, N_NEURONS=4, LEAK_SHIFT=3, IN_SHIFT=1, THRESH_INIT=127, REFRACTORY=2):
1. Release reset; en=1; current=200 constant.
   - Neuron 0 state_out per own slot: 100, then 0 with spike_valid and spike_id=0, then 0, 0 (refractory), then 100, then spike.
   - All neurons give the same pattern. frame_done pulses every 4th cycle.
2. Saturation: thr_we=1, thr_data=255; then current=255.
   - Neuron 0 values: 127, 239, then 337 saturates to 255.
   - 255 >= 255, so neuron 0 spikes and v=0.
3. Leak decay: current=200 for one frame (v=100 in all neurons), then current=0.
   - Neuron 0 values: 88, 77, 68, 60. No spikes.
4. en deasserted for 3 cycles while tm_idx=2.
   - tm_idx stays 2. spike, v and r are unchanged. spike_valid=0 and frame_done=0.
   - Resumes at slot 2 with identical values afterwards.
5. Assert rst while neuron 1 has v=100 and r[2]=1.
   - Next cycles: tm_idx=0, all outputs 0, threshold=127.
   - First update of neuron 1 with current=200 gives 100, not a spike.
6. Neuron 0 holds v=88; thr_we with thr_data=50 in the same cycle as its update with current=60.
   - Sum 107 < 127: no spike (old threshold applies).
   - Next own slot with current=0: 94 >= 50, so it spikes.
